// File: rtl/bhc_pkg.sv
// Shared helpers for the branch history cache: width calculation and history shifting.
package bhc_pkg;

    function automatic int bhc_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Shift a resolved outcome into a history of histW bits (histW < 32).
    function automatic int unsigned bhc_shift_hist(input int unsigned hist,
                                                   input logic        taken,
                                                   input int unsigned histW);
        return ((hist << 1) | {31'b0, taken}) & ((32'd1 << histW) - 32'd1);
    endfunction

endpackage

// File: rtl/bhc_lru.sv
// Per-set LRU age tracker: ages 0 (most recent) .. WAYS-1; picks the replacement victim.
module bhc_lru
    import bhc_pkg::*;
#(
    parameter  int WAYS  = 2,
    localparam int AGE_W = bhc_width(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             upd_en_i,
    input  logic [AGE_W-1:0] touch_way_i,
    input  logic [WAYS-1:0]  valid_i,
    output logic [AGE_W-1:0] victim_o
);

    logic [AGE_W-1:0] age_q [WAYS];
    logic [AGE_W-1:0] age_d [WAYS];
    logic [AGE_W-1:0] touchAge;
    logic [AGE_W-1:0] best;
    logic             found;

    always_comb begin
        age_d    = age_q;
        touchAge = age_q[touch_way_i];
        if (flush_i) begin
            for (int w = 0; w < WAYS; w++) age_d[w] = AGE_W'(w);
        end else if (upd_en_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == touch_way_i)
                    age_d[w] = '0;
                else if (age_q[w] < touchAge)
                    age_d[w] = age_q[w] + AGE_W'(1);
            end
        end
    end

    // Invalid ways are filled first; otherwise the oldest way, lowest index on ties.
    always_comb begin
        victim_o = '0;
        found    = 1'b0;
        best     = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_i[w]) begin
                victim_o = AGE_W'(w);
                found    = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 1; w < WAYS; w++) begin
                if (age_q[w] > age_q[best]) best = AGE_W'(w);
            end
            victim_o = best;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) age_q[w] <= AGE_W'(w);
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/branch_history_cache.sv
// Set-associative branch history cache with LRU replacement and eviction reporting.
// Define BHC_BYPASS_EN to forward same-cycle updates to a lookup of the same set.
module branch_history_cache
    import bhc_pkg::*;
#(
    parameter int PC_W   = 10,
    parameter int HIST_W = 3,
    parameter int SETS   = 16,
    parameter int WAYS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc,
    output logic              read_hit,
    output logic [HIST_W-1:0] read_history,
    input  logic              we,
    input  logic [PC_W-1:0]   update_pc,
    input  logic              branch_taken,
    output logic [HIST_W-1:0] update_history,
    output logic              evict,
    input  logic              flush
);

    localparam int IDX_W = bhc_width(SETS);
    localparam int TAG_W = PC_W - IDX_W;
    localparam int WAY_W = bhc_width(WAYS);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [HIST_W-1:0] history;
    } entry_t;

    entry_t            mem_q   [SETS][WAYS];
    entry_t            updSet  [WAYS];
    entry_t            lookSet [WAYS];
    logic [WAY_W-1:0]  victimWay [SETS];

    logic [IDX_W-1:0]  rdIdx, updIdx;
    logic [TAG_W-1:0]  rdTag, updTag;
    logic              updHit, updAccept;
    logic [WAY_W-1:0]  hitWay, wrWay;
    logic [HIST_W-1:0] newHist_d;
    logic              evict_d;
    logic              readHit_d;
    logic [HIST_W-1:0] readHist_d;

    logic              readHit_q;
    logic [HIST_W-1:0] readHist_q;
    logic [HIST_W-1:0] updHist_q;
    logic              evict_q;

    assign rdIdx     = pc[IDX_W-1:0];
    assign rdTag     = pc[PC_W-1:IDX_W];
    assign updIdx    = update_pc[IDX_W-1:0];
    assign updTag    = update_pc[PC_W-1:IDX_W];
    assign updAccept = we && !flush;

    always_comb begin
        updHit = 1'b0;
        hitWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (mem_q[updIdx][w].valid && mem_q[updIdx][w].tag == updTag) begin
                updHit = 1'b1;
                hitWay = WAY_W'(w);
            end
        end
        wrWay = updHit ? hitWay : victimWay[updIdx];
        if (updHit)
            newHist_d = HIST_W'(bhc_shift_hist(32'(mem_q[updIdx][wrWay].history),
                                               branch_taken, HIST_W));
        else
            newHist_d = {{(HIST_W-1){1'b0}}, branch_taken};
        evict_d = !updHit && mem_q[updIdx][wrWay].valid;
        updSet  = mem_q[updIdx];
        updSet[wrWay] = '{valid: 1'b1, tag: updTag, history: newHist_d};
    end

    // The lookup sees either the stored set or, when forwarding, the set as it will be after this edge.
    always_comb begin
`ifdef BHC_BYPASS_EN
        if (updAccept && updIdx == rdIdx)
            lookSet = updSet;
        else
            lookSet = mem_q[rdIdx];
`else
        lookSet = mem_q[rdIdx];
`endif
        readHit_d  = 1'b0;
        readHist_d = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (lookSet[w].valid && lookSet[w].tag == rdTag) begin
                readHit_d  = 1'b1;
                readHist_d = lookSet[w].history;
            end
        end
    end

    generate
        if (WAYS > 1) begin : g_lru
            for (genvar s = 0; s < SETS; s++) begin : g_set
                logic [WAYS-1:0] validVec;
                always_comb begin
                    validVec = '0;
                    for (int w = 0; w < WAYS; w++) validVec[w] = mem_q[s][w].valid;
                end
                bhc_lru #(.WAYS(WAYS)) u_lru (
                    .clk         (clk),
                    .rst         (rst),
                    .flush_i     (flush),
                    .upd_en_i    (updAccept && updIdx == IDX_W'(s)),
                    .touch_way_i (wrWay),
                    .valid_i     (validVec),
                    .victim_o    (victimWay[s])
                );
            end
        end else begin : g_direct
            for (genvar s = 0; s < SETS; s++) begin : g_set
                assign victimWay[s] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    mem_q[s][w] <= '0;
        end else if (flush) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    mem_q[s][w].valid <= 1'b0;
        end else if (we) begin
            mem_q[updIdx] <= updSet;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readHit_q  <= 1'b0;
            readHist_q <= '0;
            updHist_q  <= '0;
            evict_q    <= 1'b0;
        end else begin
            readHit_q  <= readHit_d;
            readHist_q <= readHist_d;
            if (flush) begin
                updHist_q <= '0;
                evict_q   <= 1'b0;
            end else if (we) begin
                updHist_q <= newHist_d;
                evict_q   <= evict_d;
            end else begin
                evict_q   <= 1'b0;
            end
        end
    end

    assign read_hit       = readHit_q;
    assign read_history   = readHist_q;
    assign update_history = updHist_q;
    assign evict          = evict_q;

endmodule

// File: tb/tb_branch_history_cache.sv
// Self-checking bench for branch_history_cache: directed scenarios plus randomized traffic
// against a recency-ordered per-set model.
module tb_branch_history_cache;

    localparam int PC_W   = 10;
    localparam int HIST_W = 3;
    localparam int SETS   = 16;
    localparam int WAYS   = 2;

    logic              clk;
    logic              rst;
    logic [PC_W-1:0]   pc;
    logic              read_hit;
    logic [HIST_W-1:0] read_history;
    logic              we;
    logic [PC_W-1:0]   update_pc;
    logic              branch_taken;
    logic [HIST_W-1:0] update_history;
    logic              evict;
    logic              flush;

    int tests = 0;
    int fails = 0;

    // Model: per set, PCs ordered most-recent first, with their histories.
    int qPc   [SETS][$];
    int qHist [SETS][$];
    bit expHit;
    int expHist;
    int expUpdHist;
    bit expEvict;

    branch_history_cache #(
        .PC_W(PC_W), .HIST_W(HIST_W), .SETS(SETS), .WAYS(WAYS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .read_hit       (read_hit),
        .read_history   (read_history),
        .we             (we),
        .update_pc      (update_pc),
        .branch_taken   (branch_taken),
        .update_history (update_history),
        .evict          (evict),
        .flush          (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelClear();
        for (int s = 0; s < SETS; s++) begin
            qPc[s].delete();
            qHist[s].delete();
        end
    endtask

    task automatic modelLookup(input int a);
        int s;
        s = a % SETS;
        expHit  = 1'b0;
        expHist = 0;
        for (int i = 0; i < qPc[s].size(); i++) begin
            if (qPc[s][i] == a) begin
                expHit  = 1'b1;
                expHist = qHist[s][i];
            end
        end
    endtask

    task automatic modelUpdate(input int a, input bit t);
        int s;
        int pos;
        int h;
        s   = a % SETS;
        pos = -1;
        for (int i = 0; i < qPc[s].size(); i++) if (qPc[s][i] == a) pos = i;
        if (pos >= 0) begin
            h = (qHist[s][pos] * 2 + int'(t)) % (1 << HIST_W);
            qPc[s].delete(pos);
            qHist[s].delete(pos);
            expEvict = 1'b0;
        end else begin
            h = int'(t);
            expEvict = (qPc[s].size() == WAYS);
            if (expEvict) begin
                void'(qPc[s].pop_back());
                void'(qHist[s].pop_back());
            end
        end
        qPc[s].push_front(a);
        qHist[s].push_front(h);
        expUpdHist = h;
    endtask

    task automatic drive(input logic [PC_W-1:0] lp, input logic w, input logic [PC_W-1:0] up,
                         input logic t, input logic f);
        pc           = lp;
        we           = w;
        update_pc    = up;
        branch_taken = t;
        flush        = f;
    endtask

    // Advance one clock edge, advance the model with the inputs seen at that edge, then settle.
    task automatic step();
        @(posedge clk);
        if (flush) begin
            modelLookup(int'(pc));
            modelClear();
            expUpdHist = 0;
            expEvict   = 1'b0;
        end else if (we) begin
`ifdef BHC_BYPASS_EN
            modelUpdate(int'(update_pc), branch_taken);
            modelLookup(int'(pc));
`else
            modelLookup(int'(pc));
            modelUpdate(int'(update_pc), branch_taken);
`endif
        end else begin
            modelLookup(int'(pc));
            expEvict = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(10'h004, 1'b0, 10'h000, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        modelClear();
        expUpdHist = 0;
        expEvict   = 1'b0;
        step();
        tests++; if (read_hit !== 1'b0) begin fails++; $display("[TB] FAIL reset_hit: got %b want 0", read_hit); end
        tests++; if (read_history !== 3'd0) begin fails++; $display("[TB] FAIL reset_hist: got %b want 000", read_history); end
        tests++; if (update_history !== 3'd0) begin fails++; $display("[TB] FAIL reset_updhist: got %b want 000", update_history); end
        tests++; if (evict !== 1'b0) begin fails++; $display("[TB] FAIL reset_evict: got %b want 0", evict); end
    endtask

    task automatic test_history();
        drive(10'h3FF, 1'b1, 10'h004, 1'b1, 1'b0);
        step();
        tests++; if (update_history !== 3'b001) begin fails++; $display("[TB] FAIL hist_first: got %b want 001", update_history); end
        tests++; if (evict !== 1'b0) begin fails++; $display("[TB] FAIL hist_first_evict: got %b want 0", evict); end
        drive(10'h004, 1'b0, 10'h000, 1'b0, 1'b0);
        step();
        tests++; if (read_hit !== 1'b1 || read_history !== 3'b001) begin fails++; $display("[TB] FAIL hist_lookup: got hit=%b hist=%b want hit=1 hist=001", read_hit, read_history); end
        drive(10'h3FF, 1'b1, 10'h004, 1'b0, 1'b0);
        step();
        tests++; if (update_history !== 3'b010) begin fails++; $display("[TB] FAIL hist_second: got %b want 010", update_history); end
        drive(10'h3FF, 1'b1, 10'h004, 1'b1, 1'b0);
        step();
        tests++; if (update_history !== 3'b101) begin fails++; $display("[TB] FAIL hist_third: got %b want 101", update_history); end
        drive(10'h004, 1'b0, 10'h000, 1'b0, 1'b0);
        step();
        tests++; if (read_hit !== 1'b1 || read_history !== 3'b101) begin fails++; $display("[TB] FAIL hist_lookup2: got hit=%b hist=%b want hit=1 hist=101", read_hit, read_history); end
    endtask

    task automatic test_eviction();
        drive(10'h000, 1'b0, 10'h000, 1'b0, 1'b1);
        step();
        drive(10'h3FF, 1'b1, 10'h004, 1'b1, 1'b0); step();
        tests++; if (evict !== 1'b0) begin fails++; $display("[TB] FAIL evict_first: got %b want 0", evict); end
        drive(10'h3FF, 1'b1, 10'h014, 1'b0, 1'b0); step();
        tests++; if (evict !== 1'b0) begin fails++; $display("[TB] FAIL evict_second: got %b want 0", evict); end
        drive(10'h3FF, 1'b1, 10'h024, 1'b1, 1'b0); step();
        tests++; if (evict !== 1'b1) begin fails++; $display("[TB] FAIL evict_third: got %b want 1", evict); end
        drive(10'h004, 1'b0, 10'h000, 1'b0, 1'b0); step();
        tests++; if (read_hit !== 1'b0) begin fails++; $display("[TB] FAIL evict_lru_gone: got hit=%b want 0", read_hit); end
        drive(10'h014, 1'b0, 10'h000, 1'b0, 1'b0); step();
        tests++; if (read_hit !== 1'b1 || read_history !== 3'b000) begin fails++; $display("[TB] FAIL evict_kept: got hit=%b hist=%b want hit=1 hist=000", read_hit, read_history); end
        drive(10'h024, 1'b0, 10'h000, 1'b0, 1'b0); step();
        tests++; if (read_hit !== 1'b1 || read_history !== 3'b001) begin fails++; $display("[TB] FAIL evict_new: got hit=%b hist=%b want hit=1 hist=001", read_hit, read_history); end
    endtask

    task automatic test_same_cycle();
        drive(10'h008, 1'b1, 10'h008, 1'b1, 1'b0);
        step();
`ifdef BHC_BYPASS_EN
        tests++; if (read_hit !== 1'b1 || read_history !== 3'b001) begin fails++; $display("[TB] FAIL same_cycle: got hit=%b hist=%b want hit=1 hist=001", read_hit, read_history); end
`else
        tests++; if (read_hit !== 1'b0 || read_history !== 3'b000) begin fails++; $display("[TB] FAIL same_cycle: got hit=%b hist=%b want hit=0 hist=000", read_hit, read_history); end
`endif
        drive(10'h008, 1'b0, 10'h000, 1'b0, 1'b0);
        step();
        tests++; if (read_hit !== 1'b1 || read_history !== 3'b001) begin fails++; $display("[TB] FAIL same_cycle_after: got hit=%b hist=%b want hit=1 hist=001", read_hit, read_history); end
    endtask

    task automatic test_flush();
        logic [PC_W-1:0] pcs [5];
        pcs[0] = 10'h031; pcs[1] = 10'h041; pcs[2] = 10'h052; pcs[3] = 10'h063; pcs[4] = 10'h085;
        for (int i = 0; i < 4; i++) begin
            drive(10'h3FF, 1'b1, pcs[i], 1'b1, 1'b0);
            step();
        end
        drive(10'h031, 1'b1, pcs[4], 1'b1, 1'b1);
        step();
        tests++; if (read_hit !== 1'b1) begin fails++; $display("[TB] FAIL flush_prelookup: got hit=%b want 1", read_hit); end
        tests++; if (update_history !== 3'b000 || evict !== 1'b0) begin fails++; $display("[TB] FAIL flush_outputs: got updhist=%b evict=%b want 000/0", update_history, evict); end
        for (int i = 0; i < 5; i++) begin
            drive(pcs[i], 1'b0, 10'h000, 1'b0, 1'b0);
            step();
            tests++; if (read_hit !== 1'b0) begin fails++; $display("[TB] FAIL flush_miss_%0d: got hit=%b want 0", i, read_hit); end
        end
        drive(10'h3FF, 1'b1, 10'h041, 1'b1, 1'b0);
        step();
        tests++; if (evict !== 1'b0 || update_history !== 3'b001) begin fails++; $display("[TB] FAIL flush_realloc: got evict=%b updhist=%b want 0/001", evict, update_history); end
    endtask

    task automatic test_async_reset();
        drive(10'h3FF, 1'b1, 10'h0A1, 1'b1, 1'b0);
        step();
        drive(10'h0A1, 1'b1, 10'h0A2, 1'b1, 1'b0);
        step();
        tests++; if (read_hit !== 1'b1 || update_history !== 3'b001) begin fails++; $display("[TB] FAIL areset_pre: got hit=%b updhist=%b want 1/001", read_hit, update_history); end
        #2 rst = 1'b1;
        #1;
        tests++; if (read_hit !== 1'b0 || read_history !== 3'b000) begin fails++; $display("[TB] FAIL areset_read: got hit=%b hist=%b want 0/000", read_hit, read_history); end
        tests++; if (update_history !== 3'b000 || evict !== 1'b0) begin fails++; $display("[TB] FAIL areset_upd: got updhist=%b evict=%b want 000/0", update_history, evict); end
        #2 rst = 1'b0;
        modelClear();
        expUpdHist = 0;
        expEvict   = 1'b0;
        drive(10'h0A1, 1'b0, 10'h000, 1'b0, 1'b0);
        step();
        tests++; if (read_hit !== 1'b0) begin fails++; $display("[TB] FAIL areset_miss_a1: got hit=%b want 0", read_hit); end
        drive(10'h0A2, 1'b0, 10'h000, 1'b0, 1'b0);
        step();
        tests++; if (read_hit !== 1'b0) begin fails++; $display("[TB] FAIL areset_miss_a2: got hit=%b want 0", read_hit); end
    endtask

    task automatic test_random();
        logic [PC_W-1:0] lp, up;
        for (int n = 0; n < 600; n++) begin
            lp = PC_W'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
            up = PC_W'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
            drive(lp, ($urandom % 4) != 0, up, 1'($urandom), ($urandom % 40) == 0);
            step();
            tests++; if (read_hit !== expHit) begin fails++; $display("[TB] FAIL rand_hit[%0d]: got %b want %b", n, read_hit, expHit); end
            tests++; if (read_history !== HIST_W'(expHist)) begin fails++; $display("[TB] FAIL rand_hist[%0d]: got %b want %0d", n, read_history, expHist); end
            tests++; if (update_history !== HIST_W'(expUpdHist)) begin fails++; $display("[TB] FAIL rand_updhist[%0d]: got %b want %0d", n, update_history, expUpdHist); end
            tests++; if (evict !== expEvict) begin fails++; $display("[TB] FAIL rand_evict[%0d]: got %b want %b", n, evict, expEvict); end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(10'h000, 1'b0, 10'h000, 1'b0, 1'b0);
        test_reset();
        test_history();
        test_eviction();
        test_same_cycle();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
